// File: rtl/cla_chunk_sequencer.sv
// Multi-word adder front end: streams NBIT-bit chunks of a WIDTH-bit add, LSB first,
// through one combinational CLA slice, registering the inter-chunk carry.

module cla_decomposed #(
    parameter int unsigned NBIT = 4,
    parameter int unsigned NNL  = 56
) (
    input  logic [NBIT-1:0] a,
    input  logic [NBIT-1:0] b,
    input  logic            c_in,
    output logic [NBIT-1:0] s,
    output logic            c_out
);
    // nl holds one row of product terms per carry; row k ORs into carry k+1
    localparam int unsigned ROW = NNL / NBIT;

    logic [NBIT-1:0] g;
    logic [NBIT-1:0] p;
    logic [NNL-1:0]  nl;
    logic [NBIT:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        logic term;
        term = 1'b0;
        nl   = '0;
        for (int k = 0; k < int'(NBIT); k++) begin
            for (int j = 0; j <= k; j++) begin
                term = g[j];
                for (int m = j + 1; m <= k; m++) begin
                    term = term & p[m];
                end
                nl[k*ROW + j] = term;
            end
            term = c_in;
            for (int m = 0; m <= k; m++) begin
                term = term & p[m];
            end
            nl[k*ROW + k + 1] = term;
        end
    end

    always_comb begin
        c    = '0;
        c[0] = c_in;
        for (int k = 0; k < int'(NBIT); k++) begin
            c[k+1] = |nl[k*ROW +: ROW];
        end
    end

    assign s     = p ^ c[NBIT-1:0];
    assign c_out = c[NBIT];
endmodule

module cla_chunk_sequencer #(
    parameter  int unsigned NBIT   = 4,
    parameter  int unsigned NNL    = 56,
    parameter  int unsigned NCHUNK = 4,
    localparam int unsigned WIDTH  = NBIT * NCHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             busy
);
    localparam int unsigned IW = $clog2(NCHUNK);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state, state_d;
    logic [IW-1:0]    idx, idx_d;
    logic             carry, carry_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] sum_d;
    logic             c_out_d;
    logic             in_ready_d, out_valid_d, busy_d;

    logic [NBIT-1:0]  slice_a, slice_b, slice_s;
    logic             slice_cout;

    assign slice_a = a_q[idx*NBIT +: NBIT];
    assign slice_b = b_q[idx*NBIT +: NBIT];

    cla_decomposed #(
        .NBIT (NBIT),
        .NNL  (NNL)
    ) u_slice (
        .a     (slice_a),
        .b     (slice_b),
        .c_in  (carry),
        .s     (slice_s),
        .c_out (slice_cout)
    );

    // Next-state and datapath; handshake flags are registered from the next state
    always_comb begin
        state_d = state;
        idx_d   = idx;
        carry_d = carry;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum;
        c_out_d = c_out;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    carry_d = c_in;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx*NBIT +: NBIT] = slice_s;
                carry_d = slice_cout;
                idx_d   = idx + 1'b1;
                if (idx == IW'(NCHUNK - 1)) begin
                    c_out_d = slice_cout;
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d == RUN) || (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sum       <= '0;
            c_out     <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            carry     <= carry_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sum       <= sum_d;
            c_out     <= c_out_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            busy      <= busy_d;
        end
    end
endmodule
